ras_driver: RTL and testbench

Front-end command generator for the speculative return-address stack: it owns the side of the interface that drives `push`/`pop`/`branch`/`close_valid`/`close_invalid`/`din` and consumes `dout`/`empty`. It decodes the in-order fetched RV32 instruction stream into stack commands and tracks outstanding conditional branches. It maps branch resolutions onto close commands while respecting the stack's ordering and spacing rules. It also returns the predicted return target one cycle after each pop.

---
 rtl/ras_driver.sv | 129 ++++++++++++
 tb/tb_ras_driver.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_driver.sv
`default_nettype none
// ============================================================================
// Module   : ras_driver
// Purpose  : Decodes fetched RV32 instructions into return-address-stack
//            commands, maps branch resolutions onto close commands, and
//            presents the popped return target one cycle after each pop.
// Revision : 1.0 - initial release
// ============================================================================
module ras_driver #(
  parameter int MAX_BRANCHES = 128,
  parameter int WIDTH        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [31:0]      in_instr,
  input  logic             res_valid,
  input  logic             res_mispredict,
  output logic             res_ready,
  output logic             ras_push,
  output logic             ras_pop,
  output logic             ras_branch,
  output logic             ras_close_valid,
  output logic             ras_close_invalid,
  output logic [WIDTH-1:0] ras_din,
  input  logic [WIDTH-1:0] ras_dout,
  input  logic             ras_empty,
  output logic             pred_valid,
  output logic [WIDTH-1:0] pred_target,
  output logic             err_unmatched
);

  localparam int              c_CW        = $clog2(MAX_BRANCHES + 1);
  localparam logic [c_CW-1:0] c_MAX       = c_CW'(MAX_BRANCHES);
  localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
  localparam logic [6:0]      c_OP_JAL    = 7'b1101111;
  localparam logic [6:0]      c_OP_JALR   = 7'b1100111;
  localparam logic [6:0]      c_OP_BRANCH = 7'b1100011;
  localparam logic [WIDTH-1:0] c_LINK_OFS = WIDTH'(4);

  logic [c_CW-1:0] r_cnt;
  logic            r_gap;
  logic            r_pop;
  logic            r_hit;
  logic            r_err;

  logic [6:0] w_op;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic       w_rd_link;
  logic       w_rs1_link;
  logic       w_is_branch;
  logic       w_push_dec;
  logic       w_pop_dec;
  logic       w_racc;
  logic       w_mis_acc;
  logic       w_acc;
  logic       w_br_acc;
  logic       w_unused_instr;

  assign w_op        = in_instr[6:0];
  assign w_rd        = in_instr[11:7];
  assign w_rs1       = in_instr[19:15];
  assign w_rd_link   = (w_rd == 5'd1) || (w_rd == 5'd5);
  assign w_rs1_link  = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
  assign w_is_branch = (w_op == c_OP_BRANCH);
  // Immediate and funct3 fields do not influence stack commands.
  assign w_unused_instr = ^{in_instr[31:20], in_instr[14:12]};

  always_comb begin
    w_push_dec = 1'b0;
    w_pop_dec  = 1'b0;
    if (w_op == c_OP_JAL) begin
      w_push_dec = w_rd_link;
    end else if (w_op == c_OP_JALR) begin
      // rd==rs1 both linked is a plain call; differing links is a coroutine swap.
      w_push_dec = w_rd_link;
      w_pop_dec  = w_rs1_link && (!w_rd_link || (w_rd != w_rs1));
    end
  end

  assign res_ready = reset_n && !r_gap;
  assign w_racc    = res_valid && res_ready;
  assign w_mis_acc = w_racc && res_mispredict;

  assign in_ready = reset_n && !w_mis_acc && !((r_cnt == c_MAX) && w_is_branch);
  assign w_acc    = in_valid && in_ready;
  assign w_br_acc = w_acc && w_is_branch;

  assign ras_push          = w_acc && w_push_dec;
  assign ras_pop           = w_acc && w_pop_dec;
  assign ras_branch        = w_br_acc;
  assign ras_close_invalid = w_mis_acc;
  assign ras_close_valid   = w_racc && !res_mispredict && (r_cnt != '0);
  assign ras_din           = ras_push ? (in_pc + c_LINK_OFS) : '0;

  assign pred_valid    = r_pop && r_hit;
  assign pred_target   = pred_valid ? ras_dout : '0;
  assign err_unmatched = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_gap <= 1'b0;
      r_pop <= 1'b0;
      r_hit <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_mis_acc) begin
        r_cnt <= '0;
      end else if (w_br_acc && !ras_close_valid) begin
        r_cnt <= r_cnt + c_ONE;
      end else if (!w_br_acc && ras_close_valid) begin
        r_cnt <= r_cnt - c_ONE;
      end
      // The stack needs a spare cycle after each close_valid to attach its vector.
      r_gap <= ras_close_valid;
      r_pop <= ras_pop;
      r_hit <= ras_pop && !ras_empty;
      if (w_racc && !res_mispredict && (r_cnt == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ras_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ras_driver
// Purpose  : Self-checking bench for ras_driver: directed scenarios plus
//            randomized traffic against a behavioural stack/counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ras_driver;

  localparam int MAXB = 4;
  localparam int W    = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_pc = '0;
  logic [31:0]  in_instr = NOP;
  logic         res_valid = 1'b0;
  logic         res_mispredict = 1'b0;
  logic         res_ready;
  logic         ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
  logic [W-1:0] ras_din;
  logic [W-1:0] ras_dout = '0;
  logic         ras_empty = 1'b1;
  logic         pred_valid;
  logic [W-1:0] pred_target;
  logic         err_unmatched;

  int n_checks = 0;
  int n_fail   = 0;

  ras_driver #(.MAX_BRANCHES(MAXB), .WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .res_valid(res_valid), .res_mispredict(res_mispredict), .res_ready(res_ready),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_branch(ras_branch),
    .ras_close_valid(ras_close_valid), .ras_close_invalid(ras_close_invalid),
    .ras_din(ras_din), .ras_dout(ras_dout), .ras_empty(ras_empty),
    .pred_valid(pred_valid), .pred_target(pred_target), .err_unmatched(err_unmatched)
  );

  always #5 clk = ~clk;

  // Reference model state: outstanding branches, close gap, sticky error, a simple stack.
  int          m_cnt;
  bit          m_gap, m_err, m_pend;
  logic [31:0] m_pend_val;
  logic [31:0] m_stack[$];

  bit          e_in_ready, e_res_ready, e_push, e_pop, e_branch, e_cv, e_ci, e_pv, e_err, e_unm;
  logic [31:0] e_din, e_tgt;

  function automatic logic [31:0] enc_jal(input logic [4:0] rd);
    return {20'h0, rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h0, rs1, 3'b000, rd, 7'b1100111};
  endfunction
  function automatic logic [31:0] enc_br();
    return {7'h0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_add();
    return {7'h0, 5'd3, 5'd2, 3'b000, 5'd4, 7'b0110011};
  endfunction
  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction
  function automatic logic [4:0] pick_reg();
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_gap = 0; m_err = 0; m_pend = 0; m_pend_val = '0;
    m_stack.delete();
  endtask

  // Called at a falling edge: drive inputs, derive expectations from the rules.
  task automatic set_inputs(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                            input bit rv, input bit mis);
    bit racc, misacc, isbr, acc;
    logic [6:0] op;
    logic [4:0] rd, rs1;
    in_valid = iv; in_instr = ins; in_pc = pc; res_valid = rv; res_mispredict = mis;
    ras_empty = (m_stack.size() == 0);
    ras_dout  = m_pend ? m_pend_val : $urandom();
    op = ins[6:0]; rd = ins[11:7]; rs1 = ins[19:15];
    e_pv = m_pend;
    e_tgt = m_pend ? m_pend_val : 32'h0;
    e_res_ready = !m_gap;
    racc   = rv && !m_gap;
    misacc = racc && mis;
    isbr   = (op == 7'b1100011);
    e_in_ready = !misacc && !(isbr && (m_cnt == MAXB));
    acc = iv && e_in_ready;
    e_push = 0; e_pop = 0;
    if (acc && op == 7'b1101111) e_push = is_link(rd);
    if (acc && op == 7'b1100111) begin
      if (is_link(rd) && !is_link(rs1)) e_push = 1;
      else if (!is_link(rd) && is_link(rs1)) e_pop = 1;
      else if (is_link(rd) && is_link(rs1)) begin
        e_push = 1;
        e_pop  = (rd != rs1);
      end
    end
    e_branch = acc && isbr;
    e_cv  = racc && !mis && (m_cnt > 0);
    e_ci  = misacc;
    e_unm = racc && !mis && (m_cnt == 0);
    e_din = e_push ? pc + 32'd4 : 32'h0;
    e_err = m_err;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_ci) m_cnt = 0;
    else m_cnt = m_cnt + int'(e_branch) - int'(e_cv);
    m_gap = e_cv;
    if (e_unm) m_err = 1;
    m_pend = 0;
    if (e_pop && m_stack.size() > 0) begin
      m_pend = 1;
      m_pend_val = m_stack.pop_back();
    end
    if (e_push) m_stack.push_back(e_din);
    @(negedge clk);
  endtask

  task automatic idle();
    set_inputs(0, NOP, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 0; res_valid = 0; res_mispredict = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    do_reset();
    set_inputs(1, enc_jal(5'd1), 32'h40, 0, 0); tick();
    set_inputs(1, enc_jalr(5'd0, 5'd1), 32'h80, 0, 0); tick();
    // A prediction is pending here; an asynchronous reset must discard it.
    reset_n = 1'b0;
    in_valid = 1; in_instr = enc_jal(5'd1); res_valid = 1; res_mispredict = 0;
    ras_dout = 32'hDEAD_BEEF; ras_empty = 0;
    #1;
    obs = {in_ready, res_ready, ras_push, ras_pop, ras_branch, ras_close_valid,
           ras_close_invalid, pred_valid, err_unmatched, |ras_din, |pred_target};
    n_checks++;
    if (obs !== 11'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=%b", obs, 11'b0);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    n_checks++;
    if (pred_valid !== 1'b0 || in_ready !== 1'b1 || res_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release got pv=%b ir=%b rr=%b exp pv=0 ir=1 rr=1",
                         pred_valid, in_ready, res_ready);
    end
    tick();
  endtask

  task automatic test_call_return();
    do_reset();
    set_inputs(1, enc_jal(5'd1), 32'h100, 0, 0);
    n_checks++;
    if (ras_push !== 1'b1 || ras_din !== 32'h104 || ras_pop !== 1'b0) begin
      n_fail++; $display("FAIL call_push got push=%b din=%h pop=%b exp push=1 din=104 pop=0",
                         ras_push, ras_din, ras_pop);
    end
    tick();
    set_inputs(1, enc_jalr(5'd0, 5'd1), 32'h180, 0, 0);
    n_checks++;
    if (ras_pop !== 1'b1 || ras_push !== 1'b0 || ras_din !== 32'h0) begin
      n_fail++; $display("FAIL return_pop got pop=%b push=%b din=%h exp pop=1 push=0 din=0",
                         ras_pop, ras_push, ras_din);
    end
    tick();
    idle();
    n_checks++;
    if (pred_valid !== 1'b1 || pred_target !== 32'h104) begin
      n_fail++; $display("FAIL return_pred got pv=%b tgt=%h exp pv=1 tgt=104", pred_valid, pred_target);
    end
    tick();
  endtask

  task automatic test_pop_empty();
    do_reset();
    set_inputs(1, enc_jalr(5'd0, 5'd1), 32'h20, 0, 0);
    n_checks++;
    if (ras_pop !== 1'b1) begin
      n_fail++; $display("FAIL empty_pop got pop=%b exp=1", ras_pop);
    end
    tick();
    idle();
    n_checks++;
    if (pred_valid !== 1'b0 || pred_target !== 32'h0) begin
      n_fail++; $display("FAIL empty_pred got pv=%b tgt=%h exp pv=0 tgt=0", pred_valid, pred_target);
    end
    tick();
  endtask

  task automatic test_branch_full();
    do_reset();
    for (int i = 0; i < MAXB; i++) begin
      set_inputs(1, enc_br(), 32'h400 + 32'(4 * i), 0, 0);
      n_checks++;
      if (in_ready !== 1'b1 || ras_branch !== 1'b1) begin
        n_fail++; $display("FAIL full_fill%0d got ir=%b br=%b exp ir=1 br=1", i, in_ready, ras_branch);
      end
      tick();
    end
    set_inputs(1, enc_br(), 32'h410, 0, 0);
    n_checks++;
    if (in_ready !== 1'b0 || ras_branch !== 1'b0) begin
      n_fail++; $display("FAIL full_block got ir=%b br=%b exp ir=0 br=0", in_ready, ras_branch);
    end
    tick();
    set_inputs(1, enc_add(), 32'h410, 0, 0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_add got ir=%b exp=1", in_ready);
    end
    tick();
    set_inputs(1, enc_br(), 32'h414, 1, 0);
    n_checks++;
    if (in_ready !== 1'b0 || ras_close_valid !== 1'b1) begin
      n_fail++; $display("FAIL full_resolve got ir=%b cv=%b exp ir=0 cv=1", in_ready, ras_close_valid);
    end
    tick();
    set_inputs(1, enc_br(), 32'h414, 0, 0);
    n_checks++;
    if (in_ready !== 1'b1 || ras_branch !== 1'b1) begin
      n_fail++; $display("FAIL full_reaccept got ir=%b br=%b exp ir=1 br=1", in_ready, ras_branch);
    end
    tick();
  endtask

  task automatic test_close_spacing();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_inputs(1, enc_br(), 32'h500, 0, 0); tick();
    end
    for (int k = 0; k < 5; k++) begin
      set_inputs(0, NOP, 32'h0, 1, 0);
      n_checks++;
      if (ras_close_valid !== ((k % 2) == 0) || res_ready !== ((k % 2) == 0)) begin
        n_fail++; $display("FAIL spacing_c%0d got cv=%b rr=%b exp=%0d", k, ras_close_valid,
                           res_ready, (k % 2) == 0);
      end
      tick();
    end
    idle();
    n_checks++;
    if (err_unmatched !== 1'b0) begin
      n_fail++; $display("FAIL spacing_err got=%b exp=0", err_unmatched);
    end
    tick();
  endtask

  task automatic test_mispredict();
    do_reset();
    set_inputs(1, enc_br(), 32'h600, 0, 0); tick();
    set_inputs(1, enc_br(), 32'h604, 0, 0); tick();
    set_inputs(1, enc_jal(5'd1), 32'h608, 1, 1);
    n_checks++;
    if (ras_close_invalid !== 1'b1 || ras_push !== 1'b0 || in_ready !== 1'b0 ||
        ras_close_valid !== 1'b0) begin
      n_fail++; $display("FAIL mispredict got ci=%b push=%b ir=%b cv=%b exp ci=1 push=0 ir=0 cv=0",
                         ras_close_invalid, ras_push, in_ready, ras_close_valid);
    end
    tick();
    set_inputs(0, NOP, 32'h0, 1, 0);
    n_checks++;
    if (ras_close_valid !== 1'b0) begin
      n_fail++; $display("FAIL mispredict_cnt0 got cv=%b exp=0", ras_close_valid);
    end
    tick();
    idle();
    n_checks++;
    if (err_unmatched !== 1'b1) begin
      n_fail++; $display("FAIL mispredict_err got=%b exp=1", err_unmatched);
    end
    tick();
  endtask

  task automatic test_coroutine_unmatched();
    do_reset();
    set_inputs(1, enc_jal(5'd1), 32'h300, 0, 0); tick();
    set_inputs(1, enc_jalr(5'd1, 5'd5), 32'h200, 0, 0);
    n_checks++;
    if (ras_pop !== 1'b1 || ras_push !== 1'b1 || ras_din !== 32'h204) begin
      n_fail++; $display("FAIL coroutine got pop=%b push=%b din=%h exp pop=1 push=1 din=204",
                         ras_pop, ras_push, ras_din);
    end
    tick();
    set_inputs(0, NOP, 32'h0, 1, 0);
    n_checks++;
    if (pred_valid !== 1'b1 || pred_target !== 32'h304 || ras_close_valid !== 1'b0 ||
        ras_close_invalid !== 1'b0 || err_unmatched !== 1'b0) begin
      n_fail++; $display("FAIL coroutine_pred got pv=%b tgt=%h cv=%b ci=%b err=%b exp 1 304 0 0 0",
                         pred_valid, pred_target, ras_close_valid, ras_close_invalid, err_unmatched);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      n_checks++;
      if (err_unmatched !== 1'b1) begin
        n_fail++; $display("FAIL unmatched_sticky%0d got=%b exp=1", i, err_unmatched);
      end
      tick();
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (err_unmatched !== 1'b0) begin
      n_fail++; $display("FAIL unmatched_clear got=%b exp=0", err_unmatched);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] ins, pc;
    logic [8:0]  obs, exp;
    bit iv, rv, mis;
    int sel;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       ins = enc_jal(pick_reg());
        1, 2:    ins = enc_jalr(pick_reg(), pick_reg());
        3:       ins = enc_br();
        4:       ins = enc_add();
        default: ins = $urandom();
      endcase
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      iv  = ($urandom_range(0, 3) != 0);
      rv  = (c < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      mis = rv && (m_cnt > 0) && ($urandom_range(0, 7) == 0);
      set_inputs(iv, ins, pc, rv, mis);
      obs = {in_ready, res_ready, ras_push, ras_pop, ras_branch, ras_close_valid,
             ras_close_invalid, pred_valid, err_unmatched};
      exp = {e_in_ready, e_res_ready, e_push, e_pop, e_branch, e_cv, e_ci, e_pv, e_err};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL rand_ctrl c=%0d got=%b exp=%b", c, obs, exp);
      end
      n_checks++;
      if (ras_din !== e_din) begin
        n_fail++; $display("FAIL rand_din c=%0d got=%h exp=%h", c, ras_din, e_din);
      end
      n_checks++;
      if (pred_target !== e_tgt) begin
        n_fail++; $display("FAIL rand_tgt c=%0d got=%h exp=%h", c, pred_target, e_tgt);
      end
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_call_return();
    test_pop_empty();
    test_branch_full();
    test_close_spacing();
    test_mispredict();
    test_coroutine_unmatched();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
